// File: rtl/led_blink_bank_pkg.sv
// Shared types for the LED blinker bank: channel modes, the per-channel config
// record and the config-port channel-index width.
package led_bank_pkg;

  typedef enum logic [1:0] {LM_OFF, LM_ON, LM_BLINK, LM_PWM} led_mode_t;

  // Config values are carried at a fixed width so one struct serves every
  // CNT_W; the unused upper bits are tied to zero at the write port.
  localparam int VAL_W = 32;

  typedef struct packed {
    led_mode_t        mode;
    logic [VAL_W-1:0] val;
  } led_cfg_t;

  // One extra MSB beyond what NCH needs, so out-of-range writes are visible.
  function automatic int ch_width(input int nch);
    return ((nch > 1) ? $clog2(nch) : 1) + 1;
  endfunction

endpackage

// File: rtl/led_blink_bank_if.sv
// Single-cycle config write port of the LED bank, with its ack/err responses.
interface led_blink_bank_if
  import led_bank_pkg::*;
#(
  parameter int NCH   = 8,
  parameter int CNT_W = 8
);
  localparam int CH_W = ch_width(NCH);

  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  led_mode_t        cfg_mode;
  logic [CNT_W-1:0] cfg_val;
  logic             cfg_ack;
  logic             cfg_err;

  modport master (output cfg_we, cfg_ch, cfg_mode, cfg_val, input cfg_ack, cfg_err);
  modport slave  (input cfg_we, cfg_ch, cfg_mode, cfg_val, output cfg_ack, cfg_err);
endinterface

// File: rtl/led_channel.sv
// One LED driver: holds its mode/value, the BLINK tick counter and the
// registered LED output.
module led_channel
  import led_bank_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int PWM_W = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             tick,
  input  logic [PWM_W-1:0] pwm_cnt,
  input  logic             wr,
  input  led_cfg_t         wr_cfg,
  input  logic             sync,
  output logic             led
);

  led_cfg_t         cfg_q;
  logic [CNT_W-1:0] cnt_q;
  logic [VAL_W-1:0] limit;
  logic             wrap;
  logic             pwm_on;
  logic             wr_pwm_on;

  // NOTE: every signal written here gets a value on every path, starting with
  // these defaults, so no latch can be inferred.
  always_comb begin
    limit     = '0;
    wrap      = 1'b0;
    pwm_on    = 1'b0;
    wr_pwm_on = 1'b0;
    // val=0 behaves as val=1: the half-period is never shorter than one tick.
    if (cfg_q.val != '0) limit = cfg_q.val - VAL_W'(1);
    wrap      = (VAL_W'(cnt_q) == limit);
    pwm_on    = (pwm_cnt < cfg_q.val[PWM_W-1:0]);
    wr_pwm_on = (pwm_cnt < wr_cfg.val[PWM_W-1:0]);
  end

  // NOTE: the config registers are a handful of flops, not a memory, so they
  // take the async reset like everything else and come up as OFF with val=1.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cfg_q <= '{mode: LM_OFF, val: VAL_W'(1)};
      cnt_q <= '0;
      led   <= 1'b0;
    end else if (wr) begin
      // A write takes priority over a tick or sync in the same cycle.
      cfg_q <= wr_cfg;
      cnt_q <= '0;
      led   <= (wr_cfg.mode == LM_ON) || ((wr_cfg.mode == LM_PWM) && wr_pwm_on);
    end else begin
      // NOTE: non-blocking assignments for all state, so every flop samples
      // the values from before this edge.
      case (cfg_q.mode)
        LM_OFF: led <= 1'b0;
        LM_ON:  led <= 1'b1;
        LM_PWM: led <= pwm_on;
        LM_BLINK: begin
          if (sync) begin
            cnt_q <= '0;
            led   <= 1'b0;
          end else if (tick) begin
            if (wrap) begin
              cnt_q <= '0;
              led   <= ~led;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        default: led <= 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/led_blink_bank.sv
// Bank of NCH LED drivers sharing one tick prescaler and one PWM counter,
// configured through a single-cycle write port.
module led_blink_bank
  import led_bank_pkg::*;
#(
  parameter int NCH      = 8,
  parameter int PRESCALE = 100000,
  parameter int CNT_W    = 8,
  parameter int PWM_W    = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  led_blink_bank_if.slave  cfg,
  input  logic             sync_in,
  output logic             tick,
  output logic [NCH-1:0]   led
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0]  presc_q;
  logic [PWM_W-1:0] pwm_q;
  logic             presc_end;
  logic             ch_ok;
  led_cfg_t         wr_cfg;

  always_comb begin
    presc_end = (presc_q == PS_W'(PRESCALE - 1));
    ch_ok     = (int'(cfg.cfg_ch) < NCH);
    wr_cfg    = '{mode: cfg.cfg_mode, val: VAL_W'(cfg.cfg_val)};
  end

  // sync_in restarts both shared counters and swallows the tick due next.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      presc_q <= '0;
      pwm_q   <= '0;
      tick    <= 1'b0;
    end else begin
      tick    <= presc_end && !sync_in;
      presc_q <= (sync_in || presc_end) ? '0 : presc_q + PS_W'(1);
      pwm_q   <= sync_in ? '0 : pwm_q + PWM_W'(1);
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cfg.cfg_ack <= 1'b0;
      cfg.cfg_err <= 1'b0;
    end else begin
      cfg.cfg_ack <= cfg.cfg_we && ch_ok;
      cfg.cfg_err <= cfg.cfg_we && !ch_ok;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    led_channel #(
      .CNT_W (CNT_W),
      .PWM_W (PWM_W)
    ) u_ch (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .tick    (tick),
      .pwm_cnt (pwm_q),
      .wr      (cfg.cfg_we && (int'(cfg.cfg_ch) == i)),
      .wr_cfg  (wr_cfg),
      .sync    (sync_in),
      .led     (led[i])
    );
  end

endmodule
